// File: rtl/cond_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cond_inv_pkg
// Description : Op/state enums and op-to-mask decode for the conditional
//               inverter sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cond_inv_pkg;

    localparam int c_MAX_WIDTH = 64;

    typedef enum logic [1:0] {
        PASS  = 2'b00,
        INV   = 2'b01,
        NEG   = 2'b10,
        LOINV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        EVAL    = 3'd2,
        HOLD    = 3'd3,
        RECOVER = 3'd4
    } state_e;

    // Result is {mask, cin} right-justified; callers truncate to WIDTH+1 bits.
    function automatic logic [c_MAX_WIDTH:0] mask_of(input op_e op, input int unsigned width);
        logic [c_MAX_WIDTH:0] w_res;
        w_res = '0;
        for (int unsigned i = 0; i < c_MAX_WIDTH; i++) begin
            case (op)
                INV, NEG: w_res[i+1] = (i < width);
                LOINV:    w_res[i+1] = (i < width / 2);
                default:  w_res[i+1] = 1'b0;
            endcase
        end
        w_res[0] = (op == NEG);
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_inv_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : cond_inv_seq_if
// Description : Request, datapath-drive and response bundle of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface cond_inv_seq_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [WIDTH-1:0] req_a0;
    logic [WIDTH-1:0] req_a1;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_cin;
    logic             dp_phase_pos;
    logic             dp_phase_neg;
    logic             dp_capture;
    logic             rsp_valid;
    logic             rsp_id;
    logic             rsp_ready;
    logic             busy;

    // Requesters / response consumer side
    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, rsp_ready,
        input  req_ready, dp_a, dp_b, dp_cin, dp_phase_pos, dp_phase_neg,
               dp_capture, rsp_valid, rsp_id, busy
    );

    // Sequencer side
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, rsp_ready,
        output req_ready, dp_a, dp_b, dp_cin, dp_phase_pos, dp_phase_neg,
               dp_capture, rsp_valid, rsp_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter; ties go to the requester that
//               was not served last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic [1:0] i_req,
    output logic      [1:0] o_grant
);

    logic       r_last;
    logic [1:0] w_grant;

    always_comb begin
        w_grant = 2'b00;
        case (i_req)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (|w_grant) begin
            r_last <= w_grant[1];
        end
    end

    assign o_grant = w_grant;

endmodule
`default_nettype wire

// File: rtl/cond_inv_seq.sv
`default_nettype none
// ============================================================================
// Module      : cond_inv_seq
// Description : Two-port arbitrated sequencer stepping the adiabatic
//               conditional-inverter through SETUP/EVAL/HOLD/RECOVER.
// Revision    : 1.0 - initial release
// ============================================================================
module cond_inv_seq
    import cond_inv_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int EVAL_CYC  = 2,
    parameter int RECOV_CYC = 1
) (
    input wire logic      clk,
    input wire logic      rst,
    cond_inv_seq_if.slave bus
);

    localparam int c_CNT_MAX = (EVAL_CYC > RECOV_CYC) ? EVAL_CYC : RECOV_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_EVAL_LAST  = c_CNT_W'(EVAL_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_RECOV_LAST = c_CNT_W'(RECOV_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    generate
        if (WIDTH % 2 != 0) begin : g_chk_width_even
            $error("cond_inv_seq: WIDTH must be even");
        end
        if (WIDTH > c_MAX_WIDTH) begin : g_chk_width_max
            $error("cond_inv_seq: WIDTH exceeds c_MAX_WIDTH");
        end
        if (EVAL_CYC < 1) begin : g_chk_eval
            $error("cond_inv_seq: EVAL_CYC must be >= 1");
        end
        if (RECOV_CYC < 1) begin : g_chk_recov
            $error("cond_inv_seq: RECOV_CYC must be >= 1");
        end
    endgenerate

    state_e             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_dp_a;
    logic [WIDTH-1:0]   r_dp_b;
    logic               r_dp_cin;
    logic               r_phase_pos;
    logic               r_phase_neg;
    logic               r_capture;
    logic               r_rsp_valid;
    logic               r_rsp_id;
    logic               r_id;

    logic               w_idle;
    logic [1:0]         w_arb_req;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_sel_id;
    op_e                w_sel_op;
    logic [WIDTH-1:0]   w_sel_a;

    assign w_idle    = (r_state == IDLE);
    assign w_arb_req = bus.req_valid & {2{w_idle}};

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_arb_req),
        .o_grant (w_grant)
    );

    assign w_accept = |w_grant;
    assign w_sel_id = w_grant[1];
    assign w_sel_op = w_sel_id ? op_e'(bus.req_op1) : op_e'(bus.req_op0);
    assign w_sel_a  = w_sel_id ? bus.req_a1 : bus.req_a0;

    // Outputs are registered for the state being entered, so operand and mask
    // are already stable on the first SETUP cycle and cleared on return to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_cin    <= 1'b0;
            r_phase_pos <= 1'b0;
            r_phase_neg <= 1'b0;
            r_capture   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_id        <= 1'b0;
        end else begin
            r_capture <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state              <= SETUP;
                        r_dp_a               <= w_sel_a;
                        {r_dp_b, r_dp_cin}   <= (WIDTH+1)'(mask_of(w_sel_op, WIDTH));
                        r_id                 <= w_sel_id;
                    end
                end
                SETUP: begin
                    r_state     <= EVAL;
                    r_cnt       <= '0;
                    r_phase_pos <= 1'b1;
                end
                EVAL: begin
                    if (r_cnt == c_EVAL_LAST) begin
                        r_state     <= HOLD;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_id;
                        r_capture   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_state     <= RECOVER;
                        r_rsp_valid <= 1'b0;
                        r_rsp_id    <= 1'b0;
                        r_phase_pos <= 1'b0;
                        r_phase_neg <= 1'b1;
                        r_cnt       <= '0;
                    end
                end
                RECOVER: begin
                    if (r_cnt == c_RECOV_LAST) begin
                        r_state     <= IDLE;
                        r_phase_neg <= 1'b0;
                        r_dp_a      <= '0;
                        r_dp_b      <= '0;
                        r_dp_cin    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = w_grant;
    assign bus.dp_a         = r_dp_a;
    assign bus.dp_b         = r_dp_b;
    assign bus.dp_cin       = r_dp_cin;
    assign bus.dp_phase_pos = r_phase_pos;
    assign bus.dp_phase_neg = r_phase_neg;
    assign bus.dp_capture   = r_capture;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_id       = r_rsp_id;
    assign bus.busy         = ~w_idle;

endmodule
`default_nettype wire

// File: tb/tb_cond_inv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_cond_inv_seq
// Description : Randomized self-checking bench for cond_inv_seq against a
//               cycle-timeline reference of the phase sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_inv_seq;

    localparam int W = 16;
    localparam int E = 2;
    localparam int R = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cond_inv_seq_if #(.WIDTH(W)) bus ();

    cond_inv_seq #(.WIDTH(W), .EVAL_CYC(E), .RECOV_CYC(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit m_last;

    function automatic logic [1:0] ref_grant(input logic [1:0] v);
        if (v == 2'b11) return m_last ? 2'b01 : 2'b10;
        return v;
    endfunction

    // {mask, cin}
    function automatic logic [W:0] ref_mask(input logic [1:0] op);
        case (op)
            2'd0:    return '0;
            2'd1:    return {{W{1'b1}}, 1'b0};
            2'd2:    return {{W{1'b1}}, 1'b1};
            default: return {{(W/2){1'b0}}, {(W/2){1'b1}}, 1'b0};
        endcase
    endfunction

    function automatic logic [2*W+8:0] obs();
        return {bus.dp_a, bus.dp_b, bus.dp_cin, bus.dp_phase_pos, bus.dp_phase_neg,
                bus.dp_capture, bus.rsp_valid, bus.rsp_id, bus.busy, bus.req_ready};
    endfunction

    // Caller sets requests at the start of an IDLE cycle; returns at the start
    // of the IDLE cycle following RECOVER.
    task automatic run_txn(input int stall, input bit keep, input int raise_k);
        logic [1:0]     g;
        bit             id;
        logic [1:0]     op;
        logic [W-1:0]   a;
        logic [W:0]     mk;
        logic [2*W+8:0] exp_v;
        logic [2*W+8:0] got;
        bit             ev, hold, rec;
        int             hs, rs, total;
        g     = ref_grant(bus.req_valid);
        id    = g[1];
        op    = id ? bus.req_op1 : bus.req_op0;
        a     = id ? bus.req_a1 : bus.req_a0;
        mk    = ref_mask(op);
        hs    = 2 + E;
        rs    = hs + stall + 1;
        total = rs + R - 1;
        @(negedge clk);
        got   = obs();
        exp_v = '0;
        exp_v[1:0] = g;
        n_cmp++;
        if (got !== exp_v) begin
            n_bad++;
            $display("FAIL accept: got %h expected %h", got, exp_v);
        end
        m_last = id;
        @(posedge clk); #1;
        if (!keep) bus.req_valid[id] = 1'b0;
        bus.rsp_ready = (1 - hs >= stall);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            ev    = (k >= 2) && (k < hs);
            hold  = (k >= hs) && (k < rs);
            rec   = (k >= rs);
            exp_v = {a, mk, ev | hold, rec, k == hs, hold, hold & id, 1'b1, 2'b00};
            got   = obs();
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++;
                $display("FAIL seq_k%0d: got %h expected %h", k, got, exp_v);
            end
            @(posedge clk); #1;
            bus.rsp_ready = (k + 1 - hs >= stall);
            if (k == raise_k) bus.req_valid[1] = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h expected 0", obs());
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL reset_release: got %h expected 0", obs());
        end
        m_last = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        bus.req_valid = 2'b11;
        bus.req_op0 = 2'($urandom_range(0, 3));
        bus.req_op1 = 2'($urandom_range(0, 3));
        bus.req_a0  = W'($urandom);
        bus.req_a1  = W'($urandom);
        repeat (4) run_txn(0, 1'b1, 0);
        bus.req_valid = 2'b00;
    endtask

    task automatic test_single_neg();
        bus.req_valid = 2'b01;
        bus.req_op0   = 2'b10;
        bus.req_a0    = 16'h1234;
        run_txn(0, 1'b0, 0);
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL neg_idle_busy: got %b expected 0", bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_loinv();
        bus.req_valid = 2'b10;
        bus.req_op1   = 2'b11;
        bus.req_a1    = 16'hA5A5;
        run_txn(0, 1'b0, 0);
    endtask

    task automatic test_backpressure();
        bus.req_valid = 2'b01;
        bus.req_op0   = 2'($urandom_range(0, 3));
        bus.req_a0    = W'($urandom);
        run_txn(3, 1'b0, 0);
    endtask

    task automatic test_reset_mid();
        bit saw_rsp;
        bus.req_valid = 2'b01;
        bus.req_op0   = 2'b10;
        bus.req_a0    = W'($urandom);
        @(negedge clk);
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_bad++;
            $display("FAIL rstmid_accept: got %b expected 01", bus.req_ready);
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.dp_phase_pos !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_eval: got %b expected 1", bus.dp_phase_pos);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs() !== '0) begin
            n_bad++;
            $display("FAIL rstmid_zero: got %h expected 0", obs());
        end
        saw_rsp = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) saw_rsp = 1'b1;
        end
        n_cmp++;
        if (saw_rsp) begin
            n_bad++;
            $display("FAIL rstmid_norsp: got 1 expected 0");
        end
        m_last = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 2'b11;
        run_txn(0, 1'b0, 0);
        bus.req_valid = 2'b00;
    endtask

    task automatic test_late_request();
        bus.req_valid = 2'b01;
        bus.req_op0   = 2'($urandom_range(0, 3));
        bus.req_a0    = W'($urandom);
        bus.req_op1   = 2'($urandom_range(0, 3));
        bus.req_a1    = W'($urandom);
        run_txn(0, 1'b0, 2);
        run_txn(0, 1'b0, 0);
        bus.req_valid = 2'b00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            bus.req_valid = 2'($urandom_range(1, 3));
            bus.req_op0   = 2'($urandom_range(0, 3));
            bus.req_op1   = 2'($urandom_range(0, 3));
            bus.req_a0    = W'($urandom);
            bus.req_a1    = W'($urandom);
            run_txn(int'($urandom_range(0, 3)), 1'b0, 0);
            bus.req_valid = 2'b00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op0   = 2'b00;
        bus.req_op1   = 2'b00;
        bus.req_a0    = '0;
        bus.req_a1    = '0;
        bus.rsp_ready = 1'b0;
        m_last        = 1'b1;
        test_reset();
        test_round_robin();
        test_single_neg();
        test_loinv();
        test_backpressure();
        test_reset_mid();
        test_late_request();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cond_inv_seq.md
# cond_inv_seq

Sequencer and two-port arbiter for the 16-bit adiabatic conditional-inverter datapath. It accepts operation requests from two requesters, round-robin arbitrated, and drives the operand and per-bit invert mask. It steps the datapath through setup, evaluate, hold and energy-recovery phases, then returns a response tagged with the requester ID. Operands and mask stay stable for the whole phase sequence, as adiabatic evaluation requires.

## Interface
Parameters:
- WIDTH, 16: datapath width; must be even.
- EVAL_CYC, 2: cycles in EVAL; must be ≥1.
- RECOV_CYC, 1: cycles in RECOVER; must be ≥1.

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  2  request valid, bit i = requester i.
- req_ready  output  2  request accepted this cycle, bit i.
- req_op0, req_op1  input  2 each  operation code per requester.
- req_a0, req_a1  input  WIDTH each  operand per requester.
- dp_a  output  WIDTH  operand to datapath.
- dp_b  output  WIDTH  per-bit invert mask to datapath.
- dp_cin  output  1  carry-in for NEG.
- dp_phase_pos  output  1  evaluate-phase power-clock enable.
- dp_phase_neg  output  1  recovery-phase power-clock enable.
- dp_capture  output  1  result-capture strobe.
- rsp_valid  output  1  response valid.
- rsp_id  output  1  requester that owns the response.
- rsp_ready  input  1  response consumer ready.
- busy  output  1  high whenever state ≠ IDLE.

## Operation
Op codes and the resulting mask/carry-in:
- 2'b00 PASS: dp_b = 0, dp_cin = 0.
- 2'b01 INV: dp_b = all ones, dp_cin = 0.
- 2'b10 NEG: dp_b = all ones, dp_cin = 1.
- 2'b11 LOINV: dp_b = {WIDTH/2 zeros, WIDTH/2 ones}, dp_cin = 0.

Arbitration:
- Requests are accepted in IDLE only. req_ready[i] = (state == IDLE) && grant[i], and at most one bit is set.
- Round-robin pointer `last` holds the requester served most recently; reset value is 1, so requester 0 wins the first tie.
- Only one valid: it is granted. Both valid: the requester ≠ `last` is granted.
- `last` updates on accept.

FSM (state, outputs, exit condition):
- IDLE: no datapath outputs. On accept, latch op/a/id and go to SETUP.
- SETUP (1 cycle): drive dp_a, dp_b, dp_cin; both phase enables low. Go to EVAL.
- EVAL (EVAL_CYC cycles): dp_phase_pos = 1. Go to HOLD.
- HOLD: dp_phase_pos = 1, rsp_valid = 1, rsp_id driven. dp_capture = 1 on the first HOLD cycle only. Stays until rsp_ready; then go to RECOVER.
- RECOVER (RECOV_CYC cycles): dp_phase_neg = 1. Go to IDLE.

Rules:
- dp_a, dp_b and dp_cin hold constant from SETUP through the last RECOVER cycle, and are 0 in IDLE.
- dp_phase_pos and dp_phase_neg are never high together.
- Requests arriving while not IDLE are ignored; req_ready stays 0 and the requester holds valid.

## Timing
- Reset: every output is 0, state = IDLE, `last` = 1. Reset mid-operation drops the in-flight op with no response; outputs are 0 in the cycle after rst.
- Latency, with accept at cycle t:
  - SETUP at t+1; EVAL from t+2 to t+1+EVAL_CYC.
  - HOLD, with rsp_valid and dp_capture, at t+2+EVAL_CYC.
  - With rsp_ready already high: RECOVER at t+3+EVAL_CYC, IDLE at t+3+EVAL_CYC+RECOV_CYC. The next accept is possible in that cycle.
- Defaults: accept t, rsp_valid t+4, RECOVER t+5, next accept t+6, giving 1 op per 6 cycles.
- Backpressure: while rsp_ready = 0 in HOLD, rsp_valid and rsp_id hold, dp_capture stays low after its first cycle, and dp_phase_pos stays high.

## Structure
- Package cond_inv_pkg contains:
  - op_e enum (PASS, INV, NEG, LOINV);
  - state_e enum (IDLE, SETUP, EVAL, HOLD, RECOVER);
  - function mask_of(op_e), returning {dp_b, dp_cin}.
- Sub-module rr_arb2 implements the 2-way round-robin grant with its `last` pointer.
- One phase counter, sized for max(EVAL_CYC, RECOV_CYC), is shared by EVAL and RECOVER.
- Elaboration-time assertions check WIDTH even, EVAL_CYC ≥ 1 and RECOV_CYC ≥ 1.

## Test plan
- Single NEG, requester 0, a = 16'h1234, rsp_ready held 1. Required:
  - req_ready[0] at cycle 0;
  - dp_b = 16'hFFFF and dp_cin = 1 during cycles 1–5;
  - dp_phase_pos high during cycles 2–4;
  - rsp_valid and dp_capture at cycle 4, rsp_id = 0;
  - dp_phase_neg at cycle 5; busy low at cycle 6.
- Both requesters continuously valid after reset. Required: grants alternate 0, 1, 0, 1 at cycles 0, 6, 12, 18.
- LOINV, a = 16'hA5A5. Required: dp_b = 16'h00FF and dp_cin = 0, stable from SETUP to RECOVER end.
- rsp_ready low for 3 cycles in HOLD. Required:
  - rsp_valid held for 4 cycles;
  - dp_capture high only on the first of them;
  - RECOVER starts the cycle after rsp_ready rises.
- rst asserted during EVAL. Required: next cycle all outputs are 0, busy = 0, no response; the next tie grants requester 0.
- Requester 1 raises valid during EVAL of a requester-0 op. Required: req_ready[1] stays 0 until IDLE, then requester 1 is accepted.
